// File: rtl/stack_pkg.sv
// Shared definitions for the stack engine: op encodings, FSM states, sizing.
package stack_pkg;
    localparam int DEPTH = 32;
    localparam int SP_W  = 5;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_PEEK = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;
endpackage

// File: rtl/stack_engine_if.sv
// Request/response handshake bundle between a client and the stack engine.
interface stack_engine_if #(parameter int DATA_W = 16);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (output req_valid, req_op, req_data, rsp_ready,
                    input  req_ready, rsp_valid, rsp_data);
    modport slave  (input  req_valid, req_op, req_data, rsp_ready,
                    output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/stack_mem.sv
// 32-entry register file: one synchronous write port, one asynchronous read
// port. Deliberately not reset so contents survive an engine reset.
module stack_mem
    import stack_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [SP_W-1:0]   waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [SP_W-1:0]   raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/stack_engine.sv
// LIFO stack engine with push/pop/peek over a valid/ready handshake.
// Peek support is compiled in with `define STACK_ENGINE_PEEK_EN; without it,
// op 10 behaves like the reserved op (sets unf_err, no response).
module stack_engine
    import stack_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = stack_pkg::DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    stack_engine_if.slave   bus,
    input  logic            err_clr,
    output logic [SP_W-1:0] sp,
    output logic            full,
    output logic            empty,
    output logic            ovf_err,
    output logic            unf_err
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rsp_q, rsp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              rdy_en_q;
    logic              acc;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    stack_mem #(.DATA_W(DATA_W)) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (cnt_q[SP_W-1:0]),
        .wdata_i (bus.req_data),
        .raddr_i (cnt_q[SP_W-1:0] - SP_W'(1)),
        .rdata_o (mem_rdata)
    );

    assign full          = (cnt_q == CNT_W'(DEPTH));
    assign empty         = (cnt_q == '0);
    assign sp            = cnt_q[SP_W-1:0];
    assign ovf_err       = ovf_q;
    assign unf_err       = unf_q;
    // rdy_en_q keeps req_ready low while in reset and until the first edge after.
    assign bus.req_ready = (state_q == IDLE) && rdy_en_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_q;
    assign acc           = bus.req_valid && bus.req_ready;

    // Next-state: op decode, count update, response capture; error set beats clear
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rsp_d   = rsp_q;
        mem_we  = 1'b0;
        ovf_d   = err_clr ? 1'b0 : ovf_q;
        unf_d   = err_clr ? 1'b0 : unf_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    case (bus.req_op)
                        OP_PUSH: begin
                            if (!full) begin
                                mem_we = 1'b1;
                                cnt_d  = cnt_q + CNT_W'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                        OP_POP: begin
                            state_d = RESP;
                            if (!empty) begin
                                cnt_d = cnt_q - CNT_W'(1);
                                rsp_d = mem_rdata;
                            end else begin
                                rsp_d = '0;
                                unf_d = 1'b1;
                            end
                        end
`ifdef STACK_ENGINE_PEEK_EN
                        OP_PEEK: begin
                            state_d = RESP;
                            if (!empty) begin
                                rsp_d = mem_rdata;
                            end else begin
                                rsp_d = '0;
                                unf_d = 1'b1;
                            end
                        end
`endif
                        default: unf_d = 1'b1;
                    endcase
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rsp_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rsp_q    <= rsp_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rdy_en_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_stack_engine.sv
// Directed bench for stack_engine; expected pop/peek data goes into a
// scoreboard queue and a monitor compares it at each response handshake.
module tb_stack_engine;
    import stack_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_clr = 1'b0;
    logic [4:0] sp;
    logic       full, empty, ovf_err, unf_err;

    int vectors = 0;
    int errors  = 0;
    logic [15:0] exp_q[$];

    stack_engine_if #(.DATA_W(16)) bus ();

    stack_engine #(.DATA_W(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_clr (err_clr),
        .sp      (sp),
        .full    (full),
        .empty   (empty),
        .ovf_err (ovf_err),
        .unf_err (unf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: compare each response as it is handed off
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got 0x%0h expected none", bus.rsp_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (bus.rsp_data !== e) begin
                    errors++;
                    $display("FAIL rsp_data: got 0x%0h expected 0x%0h", bus.rsp_data, e);
                end
            end
        end
    end

    // Issue one request; returns just after the accepting edge
    task automatic do_req(input logic [1:0] op, input logic [15:0] data, input logic clr);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            errors++;
            vectors++;
            $display("FAIL req_timeout: got ready=0 expected ready=1");
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = data;
        err_clr       = clr;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        err_clr       = 1'b0;
    endtask

    task automatic clear_errs();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;

        // Reset
        #12;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_sp", sp, 0);
        chk("rst_errs", {ovf_err, unf_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.req_ready, 1);

        // Three pushes
        do_req(OP_PUSH, 16'h1111, 0);
        do_req(OP_PUSH, 16'h2222, 0);
        do_req(OP_PUSH, 16'h3333, 0);
        @(negedge clk);
        chk("push3_sp", sp, 3);
        chk("push3_empty", empty, 0);
        chk("push3_rsp_valid", bus.rsp_valid, 0);

        // Three pops, each response one cycle after acceptance
        for (int i = 0; i < 3; i++) begin
            logic [15:0] v [3];
            v[0] = 16'h3333; v[1] = 16'h2222; v[2] = 16'h1111;
            exp_q.push_back(v[i]);
            do_req(OP_POP, 16'h0, 0);
            @(negedge clk);
            chk("pop_latency", bus.rsp_valid, 1);
        end
        @(negedge clk);
        chk("pop3_sp", sp, 0);
        chk("pop3_empty", empty, 1);

        // Fill to 32 then overflow
        for (int i = 0; i < 32; i++) do_req(OP_PUSH, 16'(i), 0);
        @(negedge clk);
        chk("fill_full", full, 1);
        chk("fill_sp", sp, 0);
        chk("fill_ovf", ovf_err, 0);
        do_req(OP_PUSH, 16'd32, 0);
        @(negedge clk);
        chk("ovf_err", ovf_err, 1);
        chk("ovf_full", full, 1);
        chk("ovf_sp", sp, 0);
        for (int i = 31; i >= 0; i--) begin
            exp_q.push_back(16'(i));
            do_req(OP_POP, 16'h0, 0);
        end
        @(negedge clk);
        @(negedge clk);
        chk("drain_empty", empty, 1);

        // Underflow and clear priority
        exp_q.push_back(16'h0);
        do_req(OP_POP, 16'h0, 0);
        @(negedge clk);
        chk("unf_rsp_valid", bus.rsp_valid, 1);
        chk("unf_set", unf_err, 1);
        exp_q.push_back(16'h0);
        do_req(OP_POP, 16'h0, 1);
        @(negedge clk);
        chk("unf_clr_race", unf_err, 1);
        chk("unf_count", sp, 0);
        clear_errs();
        @(negedge clk);
        chk("clr_unf", unf_err, 0);
        chk("clr_ovf", ovf_err, 0);

        // Reserved op: error, no response
        do_req(OP_RSVD, 16'h0, 0);
        @(negedge clk);
        chk("rsvd_no_rsp", bus.rsp_valid, 0);
        chk("rsvd_unf", unf_err, 1);
        chk("rsvd_sp", sp, 0);
        clear_errs();

        // Backpressured response
        do_req(OP_PUSH, 16'h5A5A, 0);
        bus.rsp_ready = 1'b0;
        exp_q.push_back(16'h5A5A);
        do_req(OP_POP, 16'h0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_data", bus.rsp_data, 16'h5A5A);
            chk("hold_ready", bus.req_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_valid", bus.rsp_valid, 0);
        chk("release_ready", bus.req_ready, 1);

        // Peek
        do_req(OP_PUSH, 16'hABCD, 0);
`ifdef STACK_ENGINE_PEEK_EN
        exp_q.push_back(16'hABCD);
        do_req(OP_PEEK, 16'h0, 0);
        @(negedge clk);
        chk("peek_valid", bus.rsp_valid, 1);
        chk("peek_sp", sp, 1);
        chk("peek_unf", unf_err, 0);
`else
        do_req(OP_PEEK, 16'h0, 0);
        @(negedge clk);
        chk("peek_no_rsp", bus.rsp_valid, 0);
        chk("peek_unf", unf_err, 1);
        chk("peek_sp", sp, 1);
`endif

        // Let outstanding responses drain
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/stack_engine.md
STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the stack entry width in bits.
REQ-002 The block SHALL have parameter DEPTH, fixed at 32; the pointer is 5 bits and the count is 6 bits.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  a request is present.
REQ-006 req_ready  out  1  the engine accepts a request this cycle.
REQ-007 req_op  in  2  operation: 00 push, 01 pop, 10 peek, 11 reserved.
REQ-008 req_data  in  DATA_W  push data.
REQ-009 rsp_valid  out  1  pop/peek response present.
REQ-010 rsp_ready  in  1  consumer takes the response.
REQ-011 rsp_data  out  DATA_W  response data.
REQ-012 sp  out  5  stack pointer, equal to count[4:0].
REQ-013 full  out  1  count == 32.
REQ-014 empty  out  1  count == 0.
REQ-015 ovf_err  out  1  sticky overflow flag.
REQ-016 unf_err  out  1  sticky underflow / illegal-op flag.
REQ-017 err_clr  in  1  synchronous clear of both error flags.

Function
REQ-018 A handshake SHALL occur when req_valid and req_ready are both 1 on a posedge.
REQ-019 The FSM SHALL have two states: IDLE (req_ready=1, rsp_valid=0) and RESP (req_ready=0, rsp_valid=1).
REQ-020 A push accepted with count<32 SHALL write mem[count] and increment count in the same cycle, with no response, and SHALL stay in IDLE.
REQ-021 A push accepted with count==32 SHALL leave the memory and count unchanged and SHALL set ovf_err.
REQ-022 A pop accepted with count>0 SHALL decrement count, register mem[count-1] into rsp_data, and go to RESP, so rsp_valid is asserted on the next cycle (latency 1).
REQ-023 A pop accepted with count==0 SHALL go to RESP with rsp_data=0, leave count unchanged, and set unf_err.
REQ-024 op 11 SHALL be accepted without changing the stack, SHALL set unf_err, and SHALL produce no response.
REQ-025 RESP SHALL hold rsp_valid and rsp_data stable until rsp_ready=1, then return to IDLE on that edge; the next request is accepted no earlier than the following cycle.
REQ-026 The count SHALL never wrap: no increment at 32 and no decrement at 0.
REQ-027 When err_clr is asserted in the same cycle as a new error event, the error SHALL win and the flag SHALL remain set.
REQ-028 full, empty and sp SHALL be combinational decodes of the registered count.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately force state=IDLE, count=0, rsp_valid=0, rsp_data=0, ovf_err=0, unf_err=0.
REQ-030 Reset SHALL NOT clear memory contents; a reset during RESP SHALL drop the pending response.
REQ-031 During reset, outputs SHALL read req_ready=0; after reset release, req_ready=1 from the first clk edge onward.

Configuration
REQ-032 The peek operation SHALL be controlled by macro STACK_ENGINE_PEEK_EN.
REQ-033 With STACK_ENGINE_PEEK_EN defined, peek SHALL behave as pop without changing count: with count==0 it SHALL return 0 and set unf_err.
REQ-034 Without STACK_ENGINE_PEEK_EN, op 10 SHALL be treated exactly as op 11 (REQ-024).

Structure
REQ-035 A shared package stack_pkg SHALL hold the op encodings (OP_PUSH, OP_POP, OP_PEEK, OP_RSVD), the FSM state typedef, and the constants DEPTH=32 and SP_W=5.
REQ-036 Storage SHALL be a sub-module stack_mem: a 32xDATA_W register array with one synchronous write port and one asynchronous read port, without reset.

Verification
REQ-037 Reset, then push 0x1111, 0x2222, 0x3333 -> sp=3, empty=0, no rsp_valid.
REQ-038 Then pop three times with rsp_ready=1 -> rsp_data 0x3333, 0x2222, 0x1111, each one cycle after acceptance; sp=0, empty=1.
REQ-039 Push 33 values 0..32 -> full=1 after the 32nd push; the 33rd push sets ovf_err and leaves sp=0, count=32; then popping yields 31 first.
REQ-040 Pop when empty -> rsp_data=0, unf_err=1; err_clr together with another empty pop -> unf_err stays 1; err_clr alone -> unf_err=0.
REQ-041 Pop with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data are stable and req_ready=0 throughout; rsp_ready=1 -> IDLE on the next cycle.
REQ-042 With STACK_ENGINE_PEEK_EN defined, push 0xABCD, then peek -> rsp_data=0xABCD and sp unchanged at 1; without the macro, the same peek -> unf_err=1 and no response.
